vx_mem_tag_remap: RTL and testbench

- Sits directly downstream of the cache cluster's per-port memory arbiter output, before the platform memory interface.
- Compresses the wide memory tag (cache MSHR/bypass tag plus arbiter select bits) into a narrow hardware ID drawn from a free list, and stores the original tag in a table.
- Restores the original tag on the matching read response.
- Lets the cluster drive memory controllers whose tag/ID field is narrower than the cache's internal tag.

---
 rtl/vx_mem_tag_remap_pkg.sv | 14 +
 rtl/vx_mem_tag_remap_free_list.sv | 60 ++++++
 rtl/vx_mem_tag_remap.sv | 205 ++++++++++++++++++++
 tb/tb_vx_mem_tag_remap.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_mem_tag_remap_pkg.sv
// Shared definitions for the memory tag remapper.
package vx_mem_tag_remap_pkg;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_e;

    // Number of hardware IDs addressable by a memory-side tag of the given width.
    function automatic int unsigned ids_for_width(input int unsigned width);
        return 32'd1 << width;
    endfunction

endpackage

// File: rtl/vx_mem_tag_remap_free_list.sv
// vx_tag_free_list: free bitmap of hardware IDs with lowest-free allocation,
// outstanding count and full/empty flags. An ID freed in a cycle becomes
// allocatable only from the next cycle, because allocation reads the
// registered bitmap.
module vx_tag_free_list #(
    parameter int unsigned NUM_IDS  = 16,
    parameter int unsigned ID_WIDTH = $clog2(NUM_IDS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc,
    output logic [ID_WIDTH-1:0] alloc_id,
    input  logic                free,
    input  logic [ID_WIDTH-1:0] free_id,
    output logic                free_id_busy,
    output logic [ID_WIDTH:0]   count,
    output logic                full,
    output logic                empty
);

    logic [NUM_IDS-1:0] free_q, free_d;
    logic [ID_WIDTH:0]  count_q, count_d;
    logic               free_en;

    // Priority encoder: lowest-index set bit of the registered free bitmap.
    always_comb begin
        alloc_id = '0;
        for (int unsigned i = NUM_IDS; i > 0; i--) begin
            if (free_q[i-1]) alloc_id = ID_WIDTH'(i - 1);
        end
    end

    // Returning an ID that is not allocated leaves the bitmap untouched.
    assign free_id_busy = !free_q[free_id];
    assign free_en      = free && free_id_busy;

    // Next bitmap and count; allocate and free in the same cycle both apply.
    always_comb begin
        free_d = free_q;
        if (alloc)   free_d[alloc_id] = 1'b0;
        if (free_en) free_d[free_id]  = 1'b1;
        count_d = count_q + {{ID_WIDTH{1'b0}}, alloc} - {{ID_WIDTH{1'b0}}, free_en};
    end

    // State registers: all IDs free after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_q  <= '1;
            count_q <= '0;
        end else begin
            free_q  <= free_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == (ID_WIDTH + 1)'(NUM_IDS));
    assign empty = (count_q == '0);

endmodule

// File: rtl/vx_mem_tag_remap.sv
// vx_mem_tag_remap: compresses the wide cache memory tag into a narrow ID
// from a free list, stores the wide tag in a table and restores it on the
// read response. Optional performance counters are built when
// MEM_TAG_REMAP_PERF_EN is defined.
module vx_mem_tag_remap
    import vx_mem_tag_remap_pkg::*;
#(
    parameter int unsigned DATA_SIZE     = 64,
    parameter int unsigned ADDR_WIDTH    = 26,
    parameter int unsigned TAG_IN_WIDTH  = 16,
    parameter int unsigned TAG_OUT_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_in_valid,
    output logic                     req_in_ready,
    input  logic                     req_in_rw,
    input  logic [ADDR_WIDTH-1:0]    req_in_addr,
    input  logic [DATA_SIZE-1:0]     req_in_byteen,
    input  logic [8*DATA_SIZE-1:0]   req_in_data,
    input  logic [TAG_IN_WIDTH-1:0]  req_in_tag,
    output logic                     req_out_valid,
    input  logic                     req_out_ready,
    output logic                     req_out_rw,
    output logic [ADDR_WIDTH-1:0]    req_out_addr,
    output logic [DATA_SIZE-1:0]     req_out_byteen,
    output logic [8*DATA_SIZE-1:0]   req_out_data,
    output logic [TAG_OUT_WIDTH-1:0] req_out_tag,
    input  logic                     rsp_in_valid,
    output logic                     rsp_in_ready,
    input  logic [8*DATA_SIZE-1:0]   rsp_in_data,
    input  logic [TAG_OUT_WIDTH-1:0] rsp_in_tag,
    output logic                     rsp_out_valid,
    input  logic                     rsp_out_ready,
    output logic [8*DATA_SIZE-1:0]   rsp_out_data,
    output logic [TAG_IN_WIDTH-1:0]  rsp_out_tag,
`ifdef MEM_TAG_REMAP_PERF_EN
    output logic [43:0]              perf_full_stalls,
    output logic [TAG_OUT_WIDTH:0]   perf_max_outstanding,
`endif
    output logic                     idle
);

    localparam int unsigned NUM_IDS = ids_for_width(TAG_OUT_WIDTH);

    logic                     alloc, full, empty, rsp_id_busy;
    logic [TAG_OUT_WIDTH-1:0] alloc_id;
    logic [TAG_OUT_WIDTH:0]   count;
    logic                     req_fire, rsp_fire, can_load, is_read;
    mem_op_e                  req_op;

    logic                     req_out_valid_q, req_out_valid_d;
    logic                     req_out_rw_q, req_out_rw_d;
    logic [ADDR_WIDTH-1:0]    req_out_addr_q, req_out_addr_d;
    logic [DATA_SIZE-1:0]     req_out_byteen_q, req_out_byteen_d;
    logic [8*DATA_SIZE-1:0]   req_out_data_q, req_out_data_d;
    logic [TAG_OUT_WIDTH-1:0] req_out_tag_q, req_out_tag_d;
    logic                     rsp_out_valid_q, rsp_out_valid_d;
    logic [8*DATA_SIZE-1:0]   rsp_out_data_q, rsp_out_data_d;
    logic [TAG_IN_WIDTH-1:0]  rsp_out_tag_q, rsp_out_tag_d;
    logic [TAG_IN_WIDTH-1:0]  tag_table_q [NUM_IDS];
    logic [TAG_IN_WIDTH-1:0]  tag_table_d [NUM_IDS];

    assign req_op       = mem_op_e'(req_in_rw);
    assign is_read      = (req_op == MEM_READ);
    assign can_load     = !req_out_valid_q || req_out_ready;
    // Writes stall on full as well so they never overtake a stalled read.
    assign req_in_ready = can_load && !full;
    assign req_fire     = req_in_valid && req_in_ready;
    assign alloc        = req_fire && is_read;
    assign rsp_in_ready = !rsp_out_valid_q || rsp_out_ready;
    assign rsp_fire     = rsp_in_valid && rsp_in_ready;

    vx_tag_free_list #(
        .NUM_IDS  (NUM_IDS),
        .ID_WIDTH (TAG_OUT_WIDTH)
    ) free_list (
        .clk          (clk),
        .reset        (reset),
        .alloc        (alloc),
        .alloc_id     (alloc_id),
        .free         (rsp_fire),
        .free_id      (rsp_in_tag),
        .free_id_busy (rsp_id_busy),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    // Tag table write: remember the wide tag of each allocated read.
    always_comb begin
        tag_table_d = tag_table_q;
        if (alloc) tag_table_d[alloc_id] = req_in_tag;
    end

    // Tag table storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        tag_table_q <= tag_table_d;
    end

    // Request output register: load on accept, drain on downstream ready.
    always_comb begin
        req_out_valid_d  = req_out_valid_q;
        req_out_rw_d     = req_out_rw_q;
        req_out_addr_d   = req_out_addr_q;
        req_out_byteen_d = req_out_byteen_q;
        req_out_data_d   = req_out_data_q;
        req_out_tag_d    = req_out_tag_q;
        if (req_fire) begin
            req_out_valid_d  = 1'b1;
            req_out_rw_d     = req_in_rw;
            req_out_addr_d   = req_in_addr;
            req_out_byteen_d = req_in_byteen;
            req_out_data_d   = req_in_data;
            req_out_tag_d    = is_read ? alloc_id : '0;
        end else if (req_out_ready) begin
            req_out_valid_d  = 1'b0;
        end
    end

    // Response output register: restore the wide tag from the table.
    always_comb begin
        rsp_out_valid_d = rsp_out_valid_q;
        rsp_out_data_d  = rsp_out_data_q;
        rsp_out_tag_d   = rsp_out_tag_q;
        if (rsp_fire) begin
            rsp_out_valid_d = 1'b1;
            rsp_out_data_d  = rsp_in_data;
            rsp_out_tag_d   = tag_table_q[rsp_in_tag];
        end else if (rsp_out_ready) begin
            rsp_out_valid_d = 1'b0;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_out_valid_q  <= 1'b0;
            req_out_rw_q     <= 1'b0;
            req_out_addr_q   <= '0;
            req_out_byteen_q <= '0;
            req_out_data_q   <= '0;
            req_out_tag_q    <= '0;
            rsp_out_valid_q  <= 1'b0;
            rsp_out_data_q   <= '0;
            rsp_out_tag_q    <= '0;
        end else begin
            req_out_valid_q  <= req_out_valid_d;
            req_out_rw_q     <= req_out_rw_d;
            req_out_addr_q   <= req_out_addr_d;
            req_out_byteen_q <= req_out_byteen_d;
            req_out_data_q   <= req_out_data_d;
            req_out_tag_q    <= req_out_tag_d;
            rsp_out_valid_q  <= rsp_out_valid_d;
            rsp_out_data_q   <= rsp_out_data_d;
            rsp_out_tag_q    <= rsp_out_tag_d;
        end
    end

    assign req_out_valid  = req_out_valid_q;
    assign req_out_rw     = req_out_rw_q;
    assign req_out_addr   = req_out_addr_q;
    assign req_out_byteen = req_out_byteen_q;
    assign req_out_data   = req_out_data_q;
    assign req_out_tag    = req_out_tag_q;
    assign rsp_out_valid  = rsp_out_valid_q;
    assign rsp_out_data   = rsp_out_data_q;
    assign rsp_out_tag    = rsp_out_tag_q;
    assign idle           = empty && !req_out_valid_q && !rsp_out_valid_q;

    rsp_id_allocated: assert property (@(posedge clk) disable iff (!reset)
        rsp_fire |-> rsp_id_busy)
        else $error("memory response returned unallocated id %0d", rsp_in_tag);

    count_in_range: assert property (@(posedge clk) disable iff (!reset)
        count <= (TAG_OUT_WIDTH + 1)'(NUM_IDS));

`ifdef MEM_TAG_REMAP_PERF_EN
    logic [43:0]            perf_full_stalls_q, perf_full_stalls_d;
    logic [TAG_OUT_WIDTH:0] perf_max_outstanding_q, perf_max_outstanding_d;

    // Saturating stall counter and outstanding-count high-water mark.
    always_comb begin
        perf_full_stalls_d = perf_full_stalls_q;
        if (req_in_valid && full && (perf_full_stalls_q != '1))
            perf_full_stalls_d = perf_full_stalls_q + 44'd1;
        perf_max_outstanding_d = (count > perf_max_outstanding_q) ? count : perf_max_outstanding_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_full_stalls_q     <= '0;
            perf_max_outstanding_q <= '0;
        end else begin
            perf_full_stalls_q     <= perf_full_stalls_d;
            perf_max_outstanding_q <= perf_max_outstanding_d;
        end
    end

    assign perf_full_stalls     = perf_full_stalls_q;
    assign perf_max_outstanding = perf_max_outstanding_q;
`endif

endmodule

// File: tb/tb_vx_mem_tag_remap.sv
// Self-checking bench for vx_mem_tag_remap: directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_vx_mem_tag_remap;

    localparam int DS      = 64;
    localparam int AW      = 26;
    localparam int TI      = 16;
    localparam int TO      = 4;
    localparam int DW      = 8 * DS;
    localparam int CW      = DW;
    localparam int NUM_IDS = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_in_valid, req_in_ready, req_in_rw;
    logic [AW-1:0] req_in_addr;
    logic [DS-1:0] req_in_byteen;
    logic [DW-1:0] req_in_data;
    logic [TI-1:0] req_in_tag;
    logic          req_out_valid, req_out_ready, req_out_rw;
    logic [AW-1:0] req_out_addr;
    logic [DS-1:0] req_out_byteen;
    logic [DW-1:0] req_out_data;
    logic [TO-1:0] req_out_tag;
    logic          rsp_in_valid, rsp_in_ready;
    logic [DW-1:0] rsp_in_data;
    logic [TO-1:0] rsp_in_tag;
    logic          rsp_out_valid, rsp_out_ready;
    logic [DW-1:0] rsp_out_data;
    logic [TI-1:0] rsp_out_tag;
    logic          idle;

    vx_mem_tag_remap #(
        .DATA_SIZE     (DS),
        .ADDR_WIDTH    (AW),
        .TAG_IN_WIDTH  (TI),
        .TAG_OUT_WIDTH (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_in_valid   (req_in_valid),
        .req_in_ready   (req_in_ready),
        .req_in_rw      (req_in_rw),
        .req_in_addr    (req_in_addr),
        .req_in_byteen  (req_in_byteen),
        .req_in_data    (req_in_data),
        .req_in_tag     (req_in_tag),
        .req_out_valid  (req_out_valid),
        .req_out_ready  (req_out_ready),
        .req_out_rw     (req_out_rw),
        .req_out_addr   (req_out_addr),
        .req_out_byteen (req_out_byteen),
        .req_out_data   (req_out_data),
        .req_out_tag    (req_out_tag),
        .rsp_in_valid   (rsp_in_valid),
        .rsp_in_ready   (rsp_in_ready),
        .rsp_in_data    (rsp_in_data),
        .rsp_in_tag     (rsp_in_tag),
        .rsp_out_valid  (rsp_out_valid),
        .rsp_out_ready  (rsp_out_ready),
        .rsp_out_data   (rsp_out_data),
        .rsp_out_tag    (rsp_out_tag),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: map of allocated ID -> wide tag, plus the two output slots.
    logic [TI-1:0] m_tag_of [int];
    bit            m_req_v;
    logic          m_req_rw;
    logic [AW-1:0] m_req_addr;
    logic [DS-1:0] m_req_be;
    logic [DW-1:0] m_req_data;
    logic [TO-1:0] m_req_tag;
    bit            m_rsp_v;
    logic [TI-1:0] m_rsp_tag;
    logic [DW-1:0] m_rsp_data;
    int            mem_pending[$];

    task automatic chk(input string name, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        m_tag_of.delete();
        mem_pending.delete();
        m_req_v = 0; m_req_rw = 0; m_req_addr = '0; m_req_be = '0; m_req_data = '0; m_req_tag = '0;
        m_rsp_v = 0; m_rsp_tag = '0; m_rsp_data = '0;
    endtask

    task automatic set_idle();
        req_in_valid = 0; req_in_rw = 0; req_in_addr = '0; req_in_byteen = '0;
        req_in_data = '0; req_in_tag = '0;
        rsp_in_valid = 0; rsp_in_tag = '0; rsp_in_data = '0;
        req_out_ready = 1; rsp_out_ready = 1;
    endtask

    task automatic read_req(input logic [TI-1:0] tag, input logic [AW-1:0] addr);
        req_in_valid = 1; req_in_rw = 0; req_in_addr = addr; req_in_tag = tag;
        req_in_byteen = {$urandom, $urandom}; req_in_data = rand_data();
    endtask

    task automatic send_rsp(input int id);
        rsp_in_valid = 1; rsp_in_tag = TO'(id); rsp_in_data = rand_data();
    endtask

    // One clock: check all outputs at the falling edge, advance the model, step past the rising edge.
    task automatic cycle();
        bit exp_rin, exp_sin, req_fire, rsp_fire;
        int new_id;
        @(negedge clk);
        exp_rin = (!m_req_v || req_out_ready) && (m_tag_of.num() < NUM_IDS);
        exp_sin = !m_rsp_v || rsp_out_ready;
        chk("req_in_ready",   CW'(req_in_ready),   CW'(exp_rin));
        chk("rsp_in_ready",   CW'(rsp_in_ready),   CW'(exp_sin));
        chk("req_out_valid",  CW'(req_out_valid),  CW'(m_req_v));
        chk("req_out_rw",     CW'(req_out_rw),     CW'(m_req_rw));
        chk("req_out_addr",   CW'(req_out_addr),   CW'(m_req_addr));
        chk("req_out_byteen", CW'(req_out_byteen), CW'(m_req_be));
        chk("req_out_data",   CW'(req_out_data),   CW'(m_req_data));
        chk("req_out_tag",    CW'(req_out_tag),    CW'(m_req_tag));
        chk("rsp_out_valid",  CW'(rsp_out_valid),  CW'(m_rsp_v));
        chk("rsp_out_tag",    CW'(rsp_out_tag),    CW'(m_rsp_tag));
        chk("rsp_out_data",   CW'(rsp_out_data),   CW'(m_rsp_data));
        chk("idle",           CW'(idle),           CW'(m_tag_of.num() == 0 && !m_req_v && !m_rsp_v));

        req_fire = req_in_valid && exp_rin;
        rsp_fire = rsp_in_valid && exp_sin;
        if (m_req_v && req_out_ready && !m_req_rw) mem_pending.push_back(int'(m_req_tag));
        new_id = -1;
        for (int i = NUM_IDS - 1; i >= 0; i--) if (!m_tag_of.exists(i)) new_id = i;
        if (rsp_fire) begin
            m_rsp_v    = 1;
            m_rsp_tag  = m_tag_of[int'(rsp_in_tag)];
            m_rsp_data = rsp_in_data;
            m_tag_of.delete(int'(rsp_in_tag));
            for (int k = 0; k < mem_pending.size(); k++) begin
                if (mem_pending[k] == int'(rsp_in_tag)) begin
                    mem_pending.delete(k);
                    break;
                end
            end
        end else if (rsp_out_ready) begin
            m_rsp_v = 0;
        end
        if (req_fire) begin
            m_req_v = 1; m_req_rw = req_in_rw; m_req_addr = req_in_addr;
            m_req_be = req_in_byteen; m_req_data = req_in_data;
            m_req_tag = req_in_rw ? '0 : TO'(new_id);
            if (!req_in_rw) m_tag_of[new_id] = req_in_tag;
        end else if (req_out_ready) begin
            m_req_v = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (m_tag_of.num() == 0 && !m_req_v && !m_rsp_v) begin
                done = 1;
            end else begin
                set_idle();
                if (mem_pending.size() > 0) send_rsp(mem_pending[0]);
                cycle();
            end
        end
        n_cmp++;
        assert (done) else begin
            n_bad++;
            $error("FAIL drain_timeout: observed outstanding %0d expected 0", m_tag_of.num());
        end
        set_idle();
    endtask

    logic [AW-1:0] s_addr;
    logic [TO-1:0] s_tag;
    logic [DW-1:0] s_data, s_rdata, d;
    logic [TI-1:0] s_rtag;
    logic [TI-1:0] ooo_tags [4];
    int            ooo_ids  [4];

    initial begin
        set_idle();
        model_reset();
        #1;
        chk("reset_req_out_valid", CW'(req_out_valid), CW'(1'b0));
        chk("reset_rsp_out_valid", CW'(rsp_out_valid), CW'(1'b0));
        chk("reset_idle",          CW'(idle),          CW'(1'b1));
        chk("reset_req_in_ready",  CW'(req_in_ready),  CW'(1'b1));
        chk("reset_rsp_in_ready",  CW'(rsp_in_ready),  CW'(1'b1));
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
        cycle();

        // Single read through the whole path.
        read_req(16'hBEEF, 26'h123);
        cycle();
        chk("t1_req_valid", CW'(req_out_valid), CW'(1'b1));
        chk("t1_req_tag",   CW'(req_out_tag),   CW'(4'd0));
        chk("t1_req_addr",  CW'(req_out_addr),  CW'(26'h123));
        set_idle();
        cycle();
        d = rand_data();
        rsp_in_valid = 1; rsp_in_tag = '0; rsp_in_data = d;
        cycle();
        chk("t1_rsp_valid", CW'(rsp_out_valid), CW'(1'b1));
        chk("t1_rsp_tag",   CW'(rsp_out_tag),   CW'(16'hBEEF));
        chk("t1_rsp_data",  CW'(rsp_out_data),  CW'(d));
        set_idle();
        cycle();
        cycle();
        chk("t1_idle", CW'(idle), CW'(1'b1));

        // Fill all IDs, stall the 17th read, free ID 5.
        for (int i = 0; i < NUM_IDS; i++) begin
            read_req(TI'(16'h100 + i), AW'($urandom));
            cycle();
            chk("t2_issue_id", CW'(req_out_tag), CW'(i));
        end
        read_req(16'h1FF, 26'h3AB);
        cycle();
        cycle();
        send_rsp(5);
        cycle();
        chk("t2_rsp_tag", CW'(rsp_out_tag), CW'(16'h105));
        rsp_in_valid = 0;
        cycle();
        chk("t2_reuse_id",   CW'(req_out_tag),   CW'(4'd5));
        chk("t2_reuse_addr", CW'(req_out_addr),  CW'(26'h3AB));
        drain();

        // Out-of-order returns.
        ooo_tags[0] = 16'hAAAA; ooo_tags[1] = 16'hBBBB; ooo_tags[2] = 16'hCCCC; ooo_tags[3] = 16'hDDDD;
        ooo_ids[0] = 3; ooo_ids[1] = 0; ooo_ids[2] = 2; ooo_ids[3] = 1;
        for (int i = 0; i < 4; i++) begin
            read_req(ooo_tags[i], AW'(i));
            cycle();
        end
        set_idle();
        cycle();
        for (int i = 0; i < 4; i++) begin
            send_rsp(ooo_ids[i]);
            d = rsp_in_data;
            cycle();
            chk("t3_rsp_tag",  CW'(rsp_out_tag),  CW'(ooo_tags[ooo_ids[i]]));
            chk("t3_rsp_data", CW'(rsp_out_data), CW'(d));
        end
        drain();

        // Write stalls behind a full ID pool.
        for (int i = 0; i < NUM_IDS; i++) begin
            read_req(TI'($urandom), AW'($urandom));
            cycle();
        end
        req_in_valid = 1; req_in_rw = 1; req_in_byteen = '1; req_in_addr = 26'h2222;
        req_in_data = rand_data();
        cycle();
        cycle();
        chk("t4_write_stalled", CW'(req_out_rw), CW'(1'b0));
        send_rsp(7);
        cycle();
        rsp_in_valid = 0;
        cycle();
        chk("t4_write_rw",  CW'(req_out_rw),     CW'(1'b1));
        chk("t4_write_tag", CW'(req_out_tag),    CW'(4'd0));
        chk("t4_write_be",  CW'(req_out_byteen), CW'({DS{1'b1}}));
        read_req(16'h7777, 26'h77);
        cycle();
        chk("t4_read_after_write", CW'(req_out_tag), CW'(4'd7));
        read_req(16'h8888, 26'h88);
        cycle();
        drain();

        // Backpressure on both outputs.
        for (int i = 0; i < 3; i++) begin
            read_req(TI'(16'h300 + i), AW'(i));
            cycle();
        end
        set_idle();
        cycle();
        read_req(16'h3FF, 26'h3FF);
        send_rsp(0);
        req_out_ready = 0; rsp_out_ready = 0;
        cycle();
        s_addr = req_out_addr; s_tag = req_out_tag; s_data = req_out_data;
        s_rtag = rsp_out_tag;  s_rdata = rsp_out_data;
        chk("t5_rsp_loaded", CW'(rsp_out_tag), CW'(16'h300));
        for (int i = 0; i < 5; i++) begin
            read_req(TI'($urandom), AW'($urandom));
            send_rsp(1);
            cycle();
            chk("t5_hold_addr",  CW'(req_out_addr), CW'(s_addr));
            chk("t5_hold_tag",   CW'(req_out_tag),  CW'(s_tag));
            chk("t5_hold_data",  CW'(req_out_data), CW'(s_data));
            chk("t5_hold_rtag",  CW'(rsp_out_tag),  CW'(s_rtag));
            chk("t5_hold_rdata", CW'(rsp_out_data), CW'(s_rdata));
        end
        drain();

        // Asynchronous reset with IDs outstanding.
        for (int i = 0; i < 7; i++) begin
            read_req(TI'($urandom), AW'($urandom));
            cycle();
        end
        read_req(16'h5555, 26'h55);
        cycle();
        send_rsp(mem_pending[0]);
        #2 reset = 0;
        #1;
        chk("t6_req_out_valid", CW'(req_out_valid), CW'(1'b0));
        chk("t6_rsp_out_valid", CW'(rsp_out_valid), CW'(1'b0));
        chk("t6_req_out_tag",   CW'(req_out_tag),   CW'(4'd0));
        chk("t6_req_out_addr",  CW'(req_out_addr),  CW'(26'd0));
        chk("t6_rsp_out_tag",   CW'(rsp_out_tag),   CW'(16'd0));
        chk("t6_rsp_out_data",  CW'(rsp_out_data),  CW'(0));
        chk("t6_idle",          CW'(idle),          CW'(1'b1));
        model_reset();
        set_idle();
        @(negedge clk) reset = 1;
        @(posedge clk); #1;
        read_req(16'h6666, 26'h66);
        cycle();
        chk("t6_first_id", CW'(req_out_tag), CW'(4'd0));
        drain();

        // Randomized traffic with out-of-order memory returns.
        for (int c = 0; c < 1500; c++) begin
            req_in_valid  = ($urandom_range(0, 3) != 0);
            req_in_rw     = ($urandom_range(0, 3) == 0);
            req_in_addr   = AW'($urandom);
            req_in_tag    = TI'($urandom);
            req_in_byteen = {$urandom, $urandom};
            req_in_data   = rand_data();
            req_out_ready = ($urandom_range(0, 9) < 7);
            rsp_out_ready = ($urandom_range(0, 9) < 7);
            if (mem_pending.size() > 0 && $urandom_range(0, 2) != 0)
                send_rsp(mem_pending[$urandom_range(0, mem_pending.size() - 1)]);
            else
                rsp_in_valid = 0;
            cycle();
        end
        drain();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
